fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_arbiter.sv | 142 ++++++++++++++
 tb/tb_fb_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry and arbiter state encoding shared by the framebuffer arbiter.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned CLR_CNT_W = $clog2(FB_PIXELS + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        CLEAR
    } fb_state_e;

endpackage

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads, writer writes with bounded
// starvation, and a full-frame clear fill. All RAM-facing outputs are registered.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int WR_MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int WCNT_W = (WR_MAX_WAIT < 1) ? 1 : $clog2(WR_MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0]    WAIT_MAX = WCNT_W'(WR_MAX_WAIT);
    localparam logic [CLR_CNT_W-1:0] CLR_END  = CLR_CNT_W'(FB_PIXELS);

    fb_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic                 ram_we_q, ram_we_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 clear_busy_q, clear_busy_d;
    logic [WCNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CLR_CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    logic                 consume_cycle;

    // Requests seen during an ack/valid cycle are the ones being consumed, so skip them.
    assign consume_cycle = rd_valid_q | wr_ack_q;

    always_comb begin
        state_d      = state_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        ram_we_d     = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        wr_ack_d     = 1'b0;
        clear_busy_d = clear_busy_q;
        wait_cnt_d   = wait_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d      = CLEAR;
                    ram_addr_d   = '0;
                    ram_wdata_d  = clear_value;
                    ram_we_d     = 1'b1;
                    clear_busy_d = 1'b1;
                    clr_cnt_d    = CLR_CNT_W'(1);
                end else if (!consume_cycle && rd_req && (!wr_req || wait_cnt_q < WAIT_MAX)) begin
                    state_d    = RD_ADDR;
                    ram_addr_d = rd_addr;
                    if (wr_req) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else if (!consume_cycle && wr_req) begin
                    state_d     = WR;
                    ram_addr_d  = wr_addr;
                    ram_wdata_d = wr_data;
                    ram_we_d    = 1'b1;
                    wait_cnt_d  = '0;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            WR: begin
                wr_ack_d = 1'b1;
                state_d  = IDLE;
            end
            CLEAR: begin
                // clr_cnt_q counts writes already issued; it equals the next address.
                if (clr_cnt_q == CLR_END) begin
                    clear_busy_d = 1'b0;
                    clr_cnt_d    = '0;
                    state_d      = IDLE;
                end else begin
                    ram_addr_d = ADDR_W'(clr_cnt_q);
                    clr_cnt_d  = clr_cnt_q + 1'b1;
                    ram_we_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            clear_busy_q <= 1'b0;
            wait_cnt_q   <= '0;
            clr_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_we_q     <= ram_we_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_ack_q     <= wr_ack_d;
            clear_busy_q <= clear_busy_d;
            wait_cnt_q   <= wait_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
        end
    end

    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign wr_ack     = wr_ack_q;
    assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed transaction table, contention, clear and reset
// sequences, then random read/write traffic against a shadow-memory model.
module tb_fb_arbiter;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int WMAX   = 8;
    localparam int NPIX   = 76800;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req, wr_req, clear_start;
    logic [ADDR_W-1:0] rd_addr, wr_addr, ram_addr;
    logic [DATA_W-1:0] wr_data, clear_value, rd_data, ram_wdata, ram_rdata;
    logic              rd_valid, wr_ack, clear_busy, ram_we;

    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;
    logic [DATA_W-1:0] mem    [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_MAX_WAIT(WMAX)) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clear_start(clear_start), .clear_value(clear_value), .clear_busy(clear_busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency, read-before-write, plus a preload port.
    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                           output int lat, output int hold);
        @(posedge clk); #1;
        rd_req = 1'b1; rd_addr = a; lat = -1; hold = 0; d = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c <= 2 && ram_addr == a && !ram_we) hold++;
            if (rd_valid) begin
                lat = c; d = rd_data;
                break;
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int we_n, output int we_c, output int ack_c);
        @(posedge clk); #1;
        wr_req = 1'b1; wr_addr = a; wr_data = d; we_n = 0; we_c = -1; ack_c = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ram_we) begin
                we_n++;
                if (ram_addr == a && ram_wdata == d) we_c = c;
            end
            if (wr_ack) begin
                ack_c = c;
                break;
            end
        end
        wr_req = 1'b0;
    endtask

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;   // write data, or expected read data
    } vec_t;

    vec_t              vecs [8];
    logic [DATA_W-1:0] d;
    int                lat, hold, we_n, we_c, ack_c, n, bad;
    string             seq;
    logic [ADDR_W-1:0] exp_a;

    // Random-phase requester state
    bit                rd_pend, wr_pend, allow_new;
    logic [ADDR_W-1:0] rd_a, wr_a;
    logic [DATA_W-1:0] wr_d;
    int                wr_start, rd_wait, rd_age, wr_age, overlap, spurious, stalls;

    initial begin
        reset = 1'b1; rd_req = 0; wr_req = 0; clear_start = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; clear_value = '0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        @(posedge clk); #1;
        bd_we = 1; bd_addr = 17'h04010; bd_data = 8'h5A;
        @(posedge clk); #1;
        bd_we = 0;
        @(posedge clk); #1;
        chk("reset_ram_addr", ram_addr, 0);
        chk("reset_ram_wdata", ram_wdata, 0);
        chk("reset_ram_we", ram_we, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_wr_ack", wr_ack, 0);
        chk("reset_clear_busy", clear_busy, 0);
        reset = 1'b0;

        vecs[0] = '{1'b0, 17'h04010, 8'h5A};
        vecs[1] = '{1'b1, 17'h12BFF, 8'hC3};
        vecs[2] = '{1'b0, 17'h12BFF, 8'hC3};
        vecs[3] = '{1'b1, 17'h1FF00, 8'h3C};
        vecs[4] = '{1'b0, 17'h1FF00, 8'h3C};
        vecs[5] = '{1'b1, 17'h00000, 8'h7E};
        vecs[6] = '{1'b0, 17'h00000, 8'h7E};
        vecs[7] = '{1'b0, 17'h12BFF, 8'hC3};
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, we_n, we_c, ack_c);
                chk($sformatf("vec%0d_we_cycles", i), we_n, 1);
                chk($sformatf("vec%0d_we_cycle", i), we_c, 1);
                chk($sformatf("vec%0d_ack_cycle", i), ack_c, 2);
            end else begin
                do_read(vecs[i].addr, d, lat, hold);
                chk($sformatf("vec%0d_rd_data", i), d, vecs[i].data);
                chk($sformatf("vec%0d_latency", i), lat, 3);
                chk($sformatf("vec%0d_addr_hold", i), hold, 2);
            end
        end

        // Contention: both requesters always asking.
        @(posedge clk); #1;
        rd_req = 1; rd_addr = 17'h00200; wr_req = 1; wr_addr = 17'h00100; wr_data = 8'h99;
        seq = "";
        for (int c = 0; c < 200 && seq.len() < 18; c++) begin
            @(posedge clk); #1;
            if (rd_valid && wr_ack) seq = {seq, "X"};
            else if (rd_valid) seq = {seq, "R"};
            else if (wr_ack) seq = {seq, "W"};
        end
        rd_req = 0; wr_req = 0;
        checks++;
        if (seq != "RRRRRRRRWRRRRRRRRW") begin
            failures++;
            $display("FAIL contention_order actual=%s expected=RRRRRRRRWRRRRRRRRW", seq);
        end

        // Clear with a write pending and a second clear_start mid-fill.
        @(posedge clk); #1;
        wr_req = 1; wr_addr = 17'h00300; wr_data = 8'h5C;
        clear_start = 1; clear_value = 8'h11;
        @(posedge clk); #1;
        clear_start = 0;
        n = 0; bad = 0; exp_a = '0;
        while (clear_busy && n < 80000) begin
            if (!(ram_we && ram_addr == exp_a && ram_wdata == 8'h11)) bad++;
            if (rd_valid || wr_ack) bad++;
            exp_a++; n++;
            if (n == 500) begin
                clear_start = 1; clear_value = 8'h22;
            end else begin
                clear_start = 0;
            end
            @(posedge clk); #1;
        end
        clear_start = 0;
        chk("clear_busy_cycles", n, NPIX);
        chk("clear_bad_cycles", bad, 0);
        chk("clear_we_after", ram_we, 0);
        ack_c = -1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (wr_ack) begin
                ack_c = c;
                break;
            end
        end
        wr_req = 0;
        chk("clear_then_wr_ack", ack_c, 2);
        for (int i = 0; i < NPIX; i++) shadow[i] = 8'h11;
        shadow[17'h00300] = 8'h5C;
        do_read(17'h00300, d, lat, hold);
        chk("clear_pending_write", d, 8'h5C);
        do_read(17'h12BFF, d, lat, hold);
        chk("clear_last_addr", d, 8'h11);

        // Reset in the middle of a fill.
        @(posedge clk); #1;
        clear_start = 1; clear_value = 8'h33;
        @(posedge clk); #1;
        clear_start = 0;
        n = 0;
        while (ram_addr != 17'd1000 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reached_1000", ram_addr, 1000);
        reset = 1;
        @(posedge clk); #1;
        chk("abort_ram_we", ram_we, 0);
        chk("abort_clear_busy", clear_busy, 0);
        chk("abort_rd_valid", rd_valid, 0);
        chk("abort_wr_ack", wr_ack, 0);
        chk("abort_ram_addr", ram_addr, 0);
        reset = 0;
        for (int i = 0; i <= 1000; i++) shadow[i] = 8'h33;
        do_read(17'h04010, d, lat, hold);
        chk("abort_read_data", d, 8'h11);
        chk("abort_read_latency", lat, 3);
        do_read(17'd999, d, lat, hold);
        chk("abort_partial_fill", d, shadow[999]);

        // Random traffic against the shadow memory.
        rd_pend = 0; wr_pend = 0; rd_wait = 0; rd_age = 0; wr_age = 0;
        overlap = 0; spurious = 0; stalls = 0; wr_start = 0;
        rd_a = '0; wr_a = '0; wr_d = '0;
        for (int c = 0; c < 1700; c++) begin
            allow_new = (c < 1500);
            @(posedge clk); #1;
            if (rd_valid && wr_ack) overlap++;
            if (rd_valid) begin
                if (!rd_pend) spurious++;
                chk("rnd_rd_data", rd_data, shadow[rd_a]);
                // The read was granted three cycles ago; count it only if the write was waiting then.
                if (wr_pend && wr_start <= c - 3) rd_wait++;
                chk("rnd_wait_bound", rd_wait <= WMAX, 1);
                rd_pend = 0; rd_age = 0;
            end
            if (wr_ack) begin
                if (!wr_pend) spurious++;
                shadow[wr_a] = wr_d;
                wr_pend = 0; wr_age = 0; rd_wait = 0;
            end
            if (rd_pend && ++rd_age > 200) stalls++;
            if (wr_pend && ++wr_age > 200) stalls++;
            if (!rd_pend && allow_new && ($urandom % 3) == 0) begin
                rd_pend = 1; rd_a = 17'(2000 + ($urandom % 64));
            end
            if (!wr_pend && allow_new && ($urandom % 3) == 0) begin
                wr_pend = 1; wr_a = 17'(2000 + ($urandom % 64)); wr_d = 8'($urandom);
                wr_start = c;
            end
            rd_req = rd_pend; rd_addr = rd_a;
            wr_req = wr_pend; wr_addr = wr_a; wr_data = wr_d;
        end
        chk("rnd_overlap", overlap, 0);
        chk("rnd_spurious", spurious, 0);
        chk("rnd_stalls", stalls, 0);
        chk("rnd_drained", {30'd0, rd_pend, wr_pend}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
